// File: rtl/mahponk_pkg.sv
// mahponk_pkg: shared definitions for the mahponk game-flow logic.
//   - state_e     : rally sequencer FSM encoding (3 bits)
//   - SCORE_W     : width of each player's score
//   - SIDE_LEFT / SIDE_RIGHT : serve-side encoding driven to the ball mover
//   - score_inc() : saturating score increment
package mahponk_pkg;

  localparam int SCORE_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    RALLY    = 3'd2,
    POINT    = 3'd3,
    GAMEOVER = 3'd4
  } state_e;

  localparam logic SIDE_LEFT  = 1'b1;
  localparam logic SIDE_RIGHT = 1'b0;

  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  // Saturates at all-ones so a misconfigured WIN_SCORE cannot wrap a score.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + SCORE_ONE;
  endfunction

endpackage

// File: rtl/advance_burst.sv
// advance_burst: emits a burst of one-clk ball_advance pulses separated by
// one low clk, so every pulse is a distinct edge to the ball mover.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   load          : (re)load the pulse counter with count; pending pulses dropped
//   count         : number of pulses for the next burst
//   abort         : clear the counter and silence the output (wins over load)
//   ball_advance  : registered advance strobe
module advance_burst #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             ball_advance
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adv_q, adv_d;

  always_comb begin
    cnt_d = cnt_q;
    adv_d = 1'b0;
    if (abort) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = count;
    end else if ((cnt_q != '0) && !adv_q) begin
      // A pulse only follows a low clk, giving the 1,0,1,0 pattern.
      adv_d = 1'b1;
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      adv_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      adv_q <= adv_d;
    end
  end

  assign ball_advance = adv_q;

endmodule

// File: rtl/rally_sequencer.sv
// rally_sequencer: game-flow controller for the ball mover. Holds the ball in
// reset while serving, meters ball_advance pulses per frame during a rally,
// scores outs, selects the serve side and declares the winner.
// Optional build macro: RALLY_SPEEDUP_EN -- every SPEEDUP_HITS paddle hits in
// a rally raise the pulses per frame by one (up to ADV_MAX); without it the
// rate is fixed at ADV_PER_FRAME and hit is unused.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   frame_tick     : one-clk pulse per frame
//   start          : synchronised start button (level, edge-detected here)
//   out_a / out_b  : ball out at left / right edge (point to B / A)
//   hit            : one-clk paddle-hit pulse
//   ball_reset     : registered hold to ball mover (1 outside RALLY)
//   ball_advance   : registered one-clk advance strobe
//   set_side       : serve side, 1 = left third, 0 = right third
//   score_a/b      : player scores
//   game_over      : high while in GAMEOVER
//   winner         : 0 = A, 1 = B (valid with game_over)
//   dbg_state      : current FSM state for observation
module rally_sequencer
  import mahponk_pkg::*;
#(
  parameter int unsigned WIN_SCORE     = 11,
  parameter int unsigned SERVE_FRAMES  = 60,
  parameter int unsigned ADV_PER_FRAME = 2,
  parameter int unsigned ADV_MAX       = 6,
  parameter int unsigned SPEEDUP_HITS  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               out_a,
  input  logic               out_b,
  input  logic               hit,
  output logic               ball_reset,
  output logic               ball_advance,
  output logic               set_side,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               game_over,
  output logic               winner,
  output state_e             dbg_state
);

  localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         SERVE_N  = 8'(SERVE_FRAMES);
  localparam logic [7:0]         FRM_ONE  = 8'(1);
  localparam logic [3:0]         ADV_INIT = 4'(ADV_PER_FRAME);

  state_e             state_q, state_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d, score_b_q, score_b_d;
  logic               set_side_q, set_side_d;
  logic               winner_q, winner_d;
  logic               ball_reset_q, ball_reset_d;
  logic               start_q, armed_q, start_rise;
  logic [3:0]         adv_rate;
  logic               burst_load, burst_abort;

  // armed_q masks the first clk after reset so a button already held at
  // reset release is not taken as a press.
  assign start_rise = start && !start_q && armed_q;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    set_side_d  = set_side_q;
    winner_d    = winner_q;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d     = SERVE;
          frame_cnt_d = '0;
          set_side_d  = SIDE_LEFT;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          frame_cnt_d = frame_cnt_q + FRM_ONE;
          if (frame_cnt_d == SERVE_N) begin
            state_d = RALLY;
          end
        end
      end
      RALLY: begin
        // Left-edge out wins when both edges report in the same clk.
        if (out_a) begin
          state_d    = POINT;
          score_b_d  = score_inc(score_b_q);
          set_side_d = SIDE_LEFT;
        end else if (out_b) begin
          state_d    = POINT;
          score_a_d  = score_inc(score_a_q);
          set_side_d = SIDE_RIGHT;
        end
      end
      POINT: begin
        if (score_a_q == WIN_S) begin
          state_d  = GAMEOVER;
          winner_d = 1'b0;
        end else if (score_b_q == WIN_S) begin
          state_d  = GAMEOVER;
          winner_d = 1'b1;
        end else begin
          state_d     = SERVE;
          frame_cnt_d = '0;
        end
      end
      GAMEOVER: begin
        if (start_rise) begin
          state_d     = SERVE;
          frame_cnt_d = '0;
          score_a_d   = '0;
          score_b_d   = '0;
          winner_d    = 1'b0;
          set_side_d  = SIDE_LEFT;
        end
      end
      default: state_d = IDLE;
    endcase
    ball_reset_d = (state_d != RALLY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      score_a_q    <= '0;
      score_b_q    <= '0;
      set_side_q   <= SIDE_LEFT;
      winner_q     <= 1'b0;
      ball_reset_q <= 1'b1;
      start_q      <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      score_a_q    <= score_a_d;
      score_b_q    <= score_b_d;
      set_side_q   <= set_side_d;
      winner_q     <= winner_d;
      ball_reset_q <= ball_reset_d;
      start_q      <= start;
      armed_q      <= 1'b1;
    end
  end

`ifdef RALLY_SPEEDUP_EN
  localparam logic [3:0] ADV_CAP   = 4'(ADV_MAX);
  localparam logic [3:0] HITS_LAST = 4'(SPEEDUP_HITS - 1);

  logic [3:0] hit_cnt_q, hit_cnt_d;
  logic [3:0] adv_rate_q, adv_rate_d;

  // The raised rate is only sampled by the burst at the next frame_tick load.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    adv_rate_d = adv_rate_q;
    if (state_q == POINT) begin
      hit_cnt_d  = '0;
      adv_rate_d = ADV_INIT;
    end else if ((state_q == RALLY) && hit) begin
      if (hit_cnt_q == HITS_LAST) begin
        hit_cnt_d = '0;
        if (adv_rate_q < ADV_CAP) begin
          adv_rate_d = adv_rate_q + 4'd1;
        end
      end else begin
        hit_cnt_d = hit_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q  <= '0;
      adv_rate_q <= ADV_INIT;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      adv_rate_q <= adv_rate_d;
    end
  end

  assign adv_rate = adv_rate_q;
`else
  localparam int unused_speedup_cfg = ADV_MAX + SPEEDUP_HITS;
  logic unused_hit;
  assign unused_hit = hit;
  assign adv_rate   = ADV_INIT;
`endif

  // Leaving RALLY for any reason silences the burst immediately.
  assign burst_load  = (state_q == RALLY) && frame_tick;
  assign burst_abort = (state_q != RALLY) || out_a || out_b;

  advance_burst #(.CNT_W(4)) u_burst (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (burst_load),
    .count        (adv_rate),
    .abort        (burst_abort),
    .ball_advance (ball_advance)
  );

  assign ball_reset = ball_reset_q;
  assign set_side   = set_side_q;
  assign score_a    = score_a_q;
  assign score_b    = score_b_q;
  assign game_over  = (state_q == GAMEOVER);
  assign winner     = winner_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rally_sequencer.sv
module tb_rally_sequencer;
  import mahponk_pkg::*;

  localparam int FRAME_GAP = 16;
  localparam int SERVE_N   = 60;
  localparam int WIN       = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n, frame_tick, start, out_a, out_b, hit;
  logic ball_reset, ball_advance, set_side, game_over, winner;
  logic [3:0] score_a, score_b;
  state_e dbg_state;

  always #5 clk = ~clk;

  rally_sequencer #(
    .WIN_SCORE     (WIN),
    .SERVE_FRAMES  (SERVE_N),
    .ADV_PER_FRAME (2),
    .ADV_MAX       (6),
    .SPEEDUP_HITS  (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_tick   (frame_tick),
    .start        (start),
    .out_a        (out_a),
    .out_b        (out_b),
    .hit          (hit),
    .ball_reset   (ball_reset),
    .ball_advance (ball_advance),
    .set_side     (set_side),
    .score_a      (score_a),
    .score_b      (score_b),
    .game_over    (game_over),
    .winner       (winner),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [3:0] model_a = 4'd0;
  logic [3:0] model_b = 4'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks (all start and end at a negedge) ----------------
  task automatic press_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  // Ticks frames until the ball is released; expects exactly SERVE_N ticks.
  task automatic run_serve();
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    exp_q.push_back(8'(SERVE_N));
    while (!done && n < 300) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      n++;
      if (!ball_reset) done = 1'b1;
      else @(negedge clk);
    end
    check("serve_frames", n, exp_q.pop_front());
    check("serve_to_rally", dbg_state, RALLY);
  endtask

  // One frame in RALLY: expect n pulses at odd clks after the tick, low otherwise.
  task automatic rally_frame(input int n);
    int cnt, bad;
    bit want;
    cnt = 0;
    bad = 0;
    exp_q.push_back(8'(n));
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int i = 0; i < FRAME_GAP; i++) begin
      want = ((i % 2) == 1) && (i < 2 * n);
      if (ball_advance) cnt++;
      if (ball_advance !== want) bad++;
      @(negedge clk);
    end
    check("adv_count", cnt, exp_q.pop_front());
    check("adv_shape", bad, 0);
  endtask

  // Raises an out mid-burst (one pulse sent, one pending) and checks the point.
  task automatic play_point(input bit oa, input bit ob);
    int cnt;
    bit exp_side, over;
    if (oa)      model_b = (model_b == 4'd15) ? model_b : model_b + 4'd1;
    else if (ob) model_a = (model_a == 4'd15) ? model_a : model_a + 4'd1;
    exp_side = oa ? 1'b1 : 1'b0;
    over     = (model_a == 4'(WIN)) || (model_b == 4'(WIN));
    exp_q.push_back({model_a, model_b});
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    out_a = oa;
    out_b = ob;
    @(negedge clk);
    out_a = 1'b0;
    out_b = 1'b0;
    check("point_score", {score_a, score_b}, exp_q.pop_front());
    check("point_side", set_side, exp_side);
    check("point_ball_reset", ball_reset, 1);
    check("point_state", dbg_state, POINT);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (ball_advance) cnt++;
      @(negedge clk);
    end
    check("abort_no_adv", cnt, 0);
    check("after_point_state", dbg_state, over ? GAMEOVER : SERVE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n    = 1'b0;
    start      = 1'b1;
    frame_tick = 1'b0;
    out_a      = 1'b0;
    out_b      = 1'b0;
    hit        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ball_reset", ball_reset, 1);
    check("rst_ball_advance", ball_advance, 0);
    check("rst_set_side", set_side, 1);
    check("rst_score_a", score_a, 0);
    check("rst_score_b", score_b, 0);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);
    check("rst_state", dbg_state, IDLE);

    // Button held through reset release is not a press.
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("start_held_no_edge", dbg_state, IDLE);
    start = 1'b0;
    @(negedge clk);

    press_start();
    check("start_to_serve", dbg_state, SERVE);
    check("serve_side", set_side, 1);
    check("serve_ball_reset", ball_reset, 1);

    // Stray outs and hits in SERVE are ignored.
    out_a = 1'b1;
    out_b = 1'b1;
    hit   = 1'b1;
    @(negedge clk);
    out_a = 1'b0;
    out_b = 1'b0;
    hit   = 1'b0;
    check("stray_serve_scores", {score_a, score_b}, 0);
    check("stray_serve_state", dbg_state, SERVE);

    run_serve();
    check("rally_side", set_side, 1);
    rally_frame(2);
    rally_frame(2);

    play_point(1'b1, 1'b0);          // B=1
    run_serve();
    rally_frame(2);
    play_point(1'b0, 1'b1);          // A=1, serve from right
    run_serve();
    check("serve_side_right", set_side, 0);
    play_point(1'b1, 1'b1);          // both edges: B only -> B=2
    run_serve();
    play_point(1'b1, 1'b0);          // B=3
    run_serve();
    play_point(1'b1, 1'b0);          // B=4
    while (model_a < 4'd10) begin
      run_serve();
      play_point(1'b0, 1'b1);
    end
    run_serve();
    play_point(1'b0, 1'b1);          // A=11 -> game over
    check("go_game_over", game_over, 1);
    check("go_winner", winner, 0);
    check("go_ball_reset", ball_reset, 1);

    // Scores frozen in GAMEOVER.
    out_a = 1'b1;
    @(negedge clk);
    out_a = 1'b0;
    @(negedge clk);
    check("go_frozen_scores", {score_a, score_b}, {4'd11, 4'd4});
    check("go_still_over", dbg_state, GAMEOVER);

    press_start();
    model_a = 4'd0;
    model_b = 4'd0;
    check("restart_scores", {score_a, score_b}, {model_a, model_b});
    check("restart_game_over", game_over, 0);
    check("restart_state", dbg_state, SERVE);
    check("restart_side", set_side, 1);
    check("restart_winner", winner, 0);

    run_serve();
    rally_frame(2);
    repeat (8) begin
      hit = 1'b1;
      @(negedge clk);
      hit = 1'b0;
      @(negedge clk);
    end
`ifdef RALLY_SPEEDUP_EN
    rally_frame(4);
`else
    rally_frame(2);
`endif
    play_point(1'b0, 1'b1);          // A=1, rate back to base
    run_serve();
    rally_frame(2);

    // Asynchronous reset in RALLY, checked before any clock edge.
    check("pre_reset_ball_reset", ball_reset, 0);
    #2 reset_n = 1'b0;
    #1;
    check("async_ball_reset", ball_reset, 1);
    check("async_score_a", score_a, 0);
    check("async_state", dbg_state, IDLE);
    check("async_ball_advance", ball_advance, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_state", dbg_state, IDLE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
